// File: rtl/controlpack.sv
// Shared control types for the ALU issue/write-back path.
//   alu_op_e    : ALU operation code. 4-bit field; codes 8..15 are unassigned
//                 and travel through untouched (the ALU answers them with 0).
//   alu_flag_t  : ALU status flags {carry, zero}.
//   seq_state_e : alu_sequencer FSM states.
package controlpack;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
  } alu_flag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register bank for alu_sequencer.
//   clk, rst          : clock, asynchronous active-high reset (bank cleared)
//   we, wr_addr/data  : single write port; writes to r0 are dropped
//   rd1_addr/rd1_data : combinational operand read port 1
//   rd2_addr/rd2_data : combinational operand read port 2
//   dbg_addr/dbg_data : combinational debug read port
// r0 always reads as zero regardless of storage contents.
module gp_regfile #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_BUS_WIDTH-1:0] wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_BUS_WIDTH-1:0] rd1_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd2_addr,
  output logic [DATA_BUS_WIDTH-1:0] rd2_data,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_BUS_WIDTH-1:0] dbg_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_BUS_WIDTH-1:0] bank [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      bank[wr_addr] <= wr_data;
    end
  end

  assign rd1_data = (rd1_addr == '0) ? '0 : bank[rd1_addr];
  assign rd2_data = (rd2_addr == '0) ? '0 : bank[rd2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : bank[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue/write-back stage around an external combinational ALU.
//   clk, rst         : clock, asynchronous active-high reset
//   cmd_valid/ready  : command handshake; ready only in IDLE
//   cmd_op/dst/src1/src2/use_imm/imm : command fields, sampled at handshake
//   alu_op, alu_reg1, alu_reg2       : drive the ALU (op is NOP outside EXEC)
//   alu_result, alu_flag             : ALU answer, captured at end of EXEC
//   done             : one-cycle pulse after each write-back
//   flags            : sticky status register {carry, zero}
//   rd_addr/rd_data  : combinational debug read of the register bank
// One command every four cycles: IDLE(accept) -> LOAD -> EXEC -> WB.
module alu_sequencer
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  alu_op_e                   cmd_op,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_dst,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_src1,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_src2,
  input  logic                      cmd_use_imm,
  input  logic [DATA_BUS_WIDTH-1:0] cmd_imm,
  output alu_op_e                   alu_op,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg1,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg2,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  alu_flag_t                 alu_flag,
  output logic                      done,
  output alu_flag_t                 flags,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_BUS_WIDTH-1:0] rd_data
);

  seq_state_e state, state_nxt;

  alu_op_e                   op_p0;
  logic [REG_ADDR_WIDTH-1:0] dst_p0, src1_p0, src2_p0;
  logic                      use_imm_p0;
  logic [DATA_BUS_WIDTH-1:0] imm_p0;

  logic [DATA_BUS_WIDTH-1:0] res_p2;
  alu_flag_t                 flag_p2;

  logic [DATA_BUS_WIDTH-1:0] rs1_data, rs2_data;
  logic                      wb_we;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = LOAD;
      LOAD:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);

  // Stage p0: command capture at the handshake edge
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      op_p0      <= cmd_op;
      dst_p0     <= cmd_dst;
      src1_p0    <= cmd_src1;
      src2_p0    <= cmd_src2;
      use_imm_p0 <= cmd_use_imm;
      imm_p0     <= cmd_imm;
    end
  end

  // Stage p1: operand fetch into the ALU input registers (LOAD edge)
  // Stage p2: ALU answer capture (EXEC edge); op returns to NOP so the ALU idles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op   <= OP_NOP;
      alu_reg1 <= '0;
      alu_reg2 <= '0;
      flags    <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == WB);
      case (state)
        LOAD: begin
          alu_reg1 <= rs1_data;
          alu_reg2 <= use_imm_p0 ? imm_p0 : rs2_data;
          alu_op   <= op_p0;
        end
        EXEC: alu_op <= OP_NOP;
        WB:   if (op_p0 != OP_NOP) flags <= flag_p2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      res_p2  <= alu_result;
      flag_p2 <= alu_flag;
    end
  end

  // Stage p3: write-back; the regfile itself discards writes to r0
  assign wb_we = (state == WB) && (op_p0 != OP_NOP);

  gp_regfile #(
    .DATA_BUS_WIDTH(DATA_BUS_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .wr_addr (dst_p0),
    .wr_data (res_p2),
    .rd1_addr(src1_p0),
    .rd1_data(rs1_data),
    .rd2_addr(src2_p0),
    .rd2_data(rs2_data),
    .dbg_addr(rd_addr),
    .dbg_data(rd_data)
  );

endmodule
